// File: rtl/data_memory_pkg.sv
// Shared definitions for the data memory: mapped I/O offsets and the address decoder.
// The offsets count down from the all-ones address.
package data_memory_pkg;

  localparam int unsigned IO_OUT_OFS = 0;
  localparam int unsigned IO_IN_OFS  = 1;
  localparam int unsigned TIMER_OFS  = 2;

  typedef enum logic [1:0] {
    SEL_RAM    = 2'd0,
    SEL_IO_OUT = 2'd1,
    SEL_IO_IN  = 2'd2,
    SEL_TIMER  = 2'd3
  } dmem_sel_e;

  // top_zone: the access lies within the last four addresses.
  // ofs: the access's distance below the all-ones address.
  function automatic dmem_sel_e decode_sel(input logic top_zone, input logic [1:0] ofs,
                                           input logic timer_en);
    dmem_sel_e sel;
    sel = SEL_RAM;
    if (top_zone) begin
      case (ofs)
        2'(IO_OUT_OFS): sel = SEL_IO_OUT;
        2'(IO_IN_OFS):  sel = SEL_IO_IN;
        2'(TIMER_OFS):  sel = timer_en ? SEL_TIMER : SEL_RAM;
        default:        sel = SEL_RAM;
      endcase
    end else begin
      sel = SEL_RAM;
    end
    return sel;
  endfunction

endpackage

// File: rtl/data_memory_if.sv
// CPU-side bus of the data memory: address, write data/enable and registered read data.
interface data_memory_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  we;
  logic [DATA_WIDTH-1:0] rd_data;

  modport master (output addr, output wr_data, output we, input rd_data);
  modport slave  (input addr, input wr_data, input we, output rd_data);
endinterface

// File: rtl/data_memory_timer.sv
// dmem_timer: free-running timer behind a 0..DIV-1 prescaler, CPU-loadable, with a
// one-cycle overflow pulse. Only instantiated when DMEM_TIMER_EN is defined.
module dmem_timer #(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] value,
  output logic             ovf
);

  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

  logic [PRE_W-1:0] pre_r;
  logic [WIDTH-1:0] value_r;
  logic             ovf_r;

  // Prescaler, timer value and overflow pulse; a CPU load beats a coincident tick.
  always_ff @(posedge clk) begin
    if (arst) begin
      pre_r   <= '0;
      value_r <= '0;
      ovf_r   <= 1'b0;
    end else if (load) begin
      pre_r   <= '0;
      value_r <= load_val;
      ovf_r   <= 1'b0;
    end else if (pre_r == PRE_LAST) begin
      pre_r   <= '0;
      value_r <= value_r + WIDTH'(1);
      ovf_r   <= &value_r;
    end else begin
      pre_r   <= pre_r + PRE_W'(1);
      ovf_r   <= 1'b0;
    end
  end

  assign value = value_r;
  assign ovf   = ovf_r;

endmodule

// File: rtl/data_memory.sv
// data_memory: single-port RAM with memory-mapped io_out, synchronized io_in and,
// when DMEM_TIMER_EN is defined, a prescaled timer at the third-from-top address.
module data_memory
  import data_memory_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = 8,
  parameter int MEM_DATA_WIDTH = 8,
  parameter int TIMER_DIV      = 4
) (
  input  logic                      clk,
  input  logic                      arst,
  data_memory_if.slave              bus,
  input  logic [MEM_DATA_WIDTH-1:0] io_in,
  output logic [MEM_DATA_WIDTH-1:0] io_out,
  output logic                      timer_ovf
);

`ifdef DMEM_TIMER_EN
  localparam logic TIMER_EN = 1'b1;
`else
  localparam logic TIMER_EN = 1'b0;
`endif

  logic [MEM_DATA_WIDTH-1:0] mem_r [2**MEM_ADDR_WIDTH];
  logic [MEM_DATA_WIDTH-1:0] rd_data_r;
  logic [MEM_DATA_WIDTH-1:0] io_out_r;
  logic [MEM_DATA_WIDTH-1:0] sync1_r;
  logic [MEM_DATA_WIDTH-1:0] sync2_r;
  logic [MEM_DATA_WIDTH-1:0] rd_mux_s;
  logic [MEM_DATA_WIDTH-1:0] timer_val_s;
  logic [MEM_ADDR_WIDTH-1:0] dist_s;
  logic                      wr_ok_s;
  dmem_sel_e                 sel_s;

  // Distance below all-ones decides which mapped register (if any) shadows RAM.
  assign dist_s  = ~bus.addr;
  assign sel_s   = decode_sel((dist_s >> 2) == '0, dist_s[1:0], TIMER_EN);
  assign wr_ok_s = bus.we & ~arst;

  // RAM write port; deliberately has no reset so contents survive arst.
  always_ff @(posedge clk) begin
    if (wr_ok_s && (sel_s == SEL_RAM)) begin
      mem_r[bus.addr] <= bus.wr_data;
    end
  end

  // Read mux selecting RAM or the mapped register for the current address.
  always_comb begin
    rd_mux_s = mem_r[bus.addr];
    case (sel_s)
      SEL_RAM:    rd_mux_s = mem_r[bus.addr];
      SEL_IO_OUT: rd_mux_s = io_out_r;
      SEL_IO_IN:  rd_mux_s = sync2_r;
      SEL_TIMER:  rd_mux_s = timer_val_s;
      default:    rd_mux_s = mem_r[bus.addr];
    endcase
  end

  // Registered read data, io_out register and io_in synchronizer.
  always_ff @(posedge clk) begin
    if (arst) begin
      rd_data_r <= '0;
      io_out_r  <= '0;
      sync1_r   <= '0;
      sync2_r   <= '0;
    end else begin
      rd_data_r <= rd_mux_s;
      sync1_r   <= io_in;
      sync2_r   <= sync1_r;
      if (bus.we && (sel_s == SEL_IO_OUT)) begin
        io_out_r <= bus.wr_data;
      end
    end
  end

`ifdef DMEM_TIMER_EN
  dmem_timer #(
    .WIDTH (MEM_DATA_WIDTH),
    .DIV   (TIMER_DIV)
  ) u_timer (
    .clk      (clk),
    .arst     (arst),
    .load     (bus.we && (sel_s == SEL_TIMER)),
    .load_val (bus.wr_data),
    .value    (timer_val_s),
    .ovf      (timer_ovf)
  );
`else
  assign timer_val_s = '0;
  assign timer_ovf   = 1'b0;
`endif

  assign bus.rd_data = rd_data_r;
  assign io_out      = io_out_r;

endmodule

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory; timer checks run when DMEM_TIMER_EN is defined.
module tb_data_memory;

  logic       clk = 1'b0;
  logic       arst;
  logic [7:0] io_in;
  logic [7:0] io_out;
  logic       timer_ovf;
  int         n_checks = 0;
  int         n_errors = 0;

  data_memory_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus_if ();

  data_memory #(
    .MEM_ADDR_WIDTH (8),
    .MEM_DATA_WIDTH (8),
    .TIMER_DIV      (4)
  ) dut (
    .clk       (clk),
    .arst      (arst),
    .bus       (bus_if),
    .io_in     (io_in),
    .io_out    (io_out),
    .timer_ovf (timer_ovf)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    bus_if.addr    = a;
    bus_if.wr_data = d;
    bus_if.we      = 1'b1;
    tick(1);
    bus_if.we      = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, input logic [7:0] exp, input string tag);
    bus_if.addr = a;
    bus_if.we   = 1'b0;
    tick(1);
    check_eq(tag, {24'd0, bus_if.rd_data}, {24'd0, exp});
  endtask

  logic [7:0] tbl_addr [4] = '{8'h00, 8'h01, 8'h7F, 8'hFC};
  logic [7:0] tbl_data [4] = '{8'hA5, 8'h3C, 8'h81, 8'h69};

  initial begin
    arst           = 1'b1;
    io_in          = 8'h00;
    bus_if.addr    = 8'h00;
    bus_if.wr_data = 8'h00;
    bus_if.we      = 1'b0;
    tick(2);
    check_eq("reset_rd_data", {24'd0, bus_if.rd_data}, 32'h0);
    check_eq("reset_io_out", {24'd0, io_out}, 32'h0);
    check_eq("reset_timer_ovf", {31'd0, timer_ovf}, 32'h0);
    arst = 1'b0;

    // Basic write then read with one-cycle latency.
    bus_write(8'h10, 8'h5A);
    bus_read(8'h10, 8'h5A, "ram_0x10");

    // Read-first on same-cycle read+write.
    bus_write(8'h20, 8'h11);
    bus_if.addr    = 8'h20;
    bus_if.wr_data = 8'h33;
    bus_if.we      = 1'b1;
    tick(1);
    bus_if.we      = 1'b0;
    check_eq("rfw_old", {24'd0, bus_if.rd_data}, 32'h11);
    bus_read(8'h20, 8'h33, "rfw_new");

    // Small table of RAM locations, including the last plain-RAM address.
    for (int i = 0; i < 4; i++) bus_write(tbl_addr[i], tbl_data[i]);
    for (int i = 0; i < 4; i++) bus_read(tbl_addr[i], tbl_data[i], "ram_table");

    // io_out register.
    bus_write(8'hFF, 8'hC3);
    check_eq("io_out_write", {24'd0, io_out}, 32'hC3);
    bus_read(8'hFF, 8'hC3, "io_out_read");
    bus_read(8'hFC, 8'h69, "ram_below_io");

    // io_in through the synchronizer: three clocks to rd_data.
    bus_if.addr = 8'hFE;
    io_in       = 8'h7E;
    tick(2);
    check_eq("io_in_2clk", {24'd0, bus_if.rd_data}, 32'h00);
    tick(1);
    check_eq("io_in_3clk", {24'd0, bus_if.rd_data}, 32'h7E);
    bus_write(8'hFE, 8'h00);
    bus_read(8'hFE, 8'h7E, "io_in_ro");
    check_eq("io_in_wr_no_side", {24'd0, io_out}, 32'hC3);

`ifdef DMEM_TIMER_EN
    // Count FE -> FF -> 00 with one overflow pulse.
    bus_write(8'hFD, 8'hFE);
    tick(3);
    tick(1);
    check_eq("tmr_e4_rd", {24'd0, bus_if.rd_data}, 32'hFE);
    check_eq("tmr_e4_ovf", {31'd0, timer_ovf}, 32'h0);
    tick(1);
    check_eq("tmr_ff", {24'd0, bus_if.rd_data}, 32'hFF);
    tick(3);
    check_eq("tmr_ovf_pulse", {31'd0, timer_ovf}, 32'h1);
    tick(1);
    check_eq("tmr_ovf_end", {31'd0, timer_ovf}, 32'h0);
    check_eq("tmr_wrapped", {24'd0, bus_if.rd_data}, 32'h00);

    // Write coinciding with a tick that would otherwise overflow.
    bus_write(8'hFD, 8'hFF);
    tick(3);
    bus_write(8'hFD, 8'h40);
    check_eq("tmr_load_no_ovf", {31'd0, timer_ovf}, 32'h0);
    tick(1);
    check_eq("tmr_loaded", {24'd0, bus_if.rd_data}, 32'h40);
    tick(3);
    tick(1);
    check_eq("tmr_pre_restart", {24'd0, bus_if.rd_data}, 32'h41);

    // Reset mid-count restarts the prescaler from zero.
    bus_write(8'hFD, 8'h10);
    tick(2);
    arst = 1'b1;
    tick(1);
    arst = 1'b0;
    tick(4);
    check_eq("tmr_rst_hold", {24'd0, bus_if.rd_data}, 32'h00);
    tick(1);
    check_eq("tmr_rst_first", {24'd0, bus_if.rd_data}, 32'h01);
`else
    // Without the timer, ALL1-2 is plain RAM.
    bus_write(8'hFD, 8'h99);
    bus_read(8'hFD, 8'h99, "fd_is_ram");
    check_eq("no_timer_ovf", {31'd0, timer_ovf}, 32'h0);
`endif

    // Reset mid-operation with a coincident write that must be dropped.
    bus_if.addr    = 8'h10;
    bus_if.wr_data = 8'hEE;
    bus_if.we      = 1'b1;
    arst           = 1'b1;
    tick(1);
    bus_if.we      = 1'b0;
    check_eq("mid_rst_rd_data", {24'd0, bus_if.rd_data}, 32'h0);
    check_eq("mid_rst_io_out", {24'd0, io_out}, 32'h0);
    check_eq("mid_rst_ovf", {31'd0, timer_ovf}, 32'h0);
    arst = 1'b0;
    bus_read(8'h10, 8'h5A, "ram_kept_after_rst");
    bus_read(8'hFE, 8'h00, "sync_cleared");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 The block SHALL have parameter MEM_ADDR_WIDTH, default 8, which is the data-memory address width.
REQ-002 The block SHALL have parameter MEM_DATA_WIDTH, default 8, which is the data word width.
REQ-003 The block SHALL have parameter TIMER_DIV, default 4, which is the timer prescaler divide ratio (>=1).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port arst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port addr, input, MEM_ADDR_WIDTH bits: access address, driven by the CPU MAR.
REQ-007 The block SHALL have port wr_data, input, MEM_DATA_WIDTH bits: write data, driven by the CPU MBR output.
REQ-008 The block SHALL have port we, input, 1 bit: write enable, one-cycle pulse from the CPU.
REQ-009 The block SHALL have port rd_data, output, MEM_DATA_WIDTH bits: registered read data, driven to the CPU mem_data_i.
REQ-010 The block SHALL have port io_in, input, MEM_DATA_WIDTH bits: asynchronous external input port.
REQ-011 The block SHALL have port io_out, output, MEM_DATA_WIDTH bits: registered external output port.
REQ-012 The block SHALL have port timer_ovf, output, 1 bit: one-cycle pulse on timer wrap (tied 0 if the timer is compiled out).

Function
REQ-013 The memory map SHALL be: ALL1 = io_out register; ALL1-1 = io_in (read-only); ALL1-2 = timer (when enabled); every other address = RAM. ALL1 is the all-ones address.
REQ-014 The RAM depth SHALL be 2^MEM_ADDR_WIDTH words; mapped I/O addresses shadow RAM locations and never access them.
REQ-015 rd_data SHALL be registered every cycle from addr, giving a latency of 1 clock (addr at edge N, data valid after edge N+1), independent of we.
REQ-016 A write SHALL occur at the edge where we=1: RAM[addr], io_out, or the timer is loaded with wr_data.
REQ-017 A read and write to the same address in the same cycle SHALL be read-first: rd_data shows the old value and the new value appears on the following read.
REQ-018 Writes to ALL1-1 (io_in) SHALL be ignored without side effects.
REQ-019 io_in SHALL pass through a 2-flop synchronizer; reads of ALL1-1 return the second stage, so the total input-to-rd_data delay is 3 clocks.
REQ-020 Reading ALL1 SHALL return the current io_out register value.
REQ-021 The timer SHALL have a prescaler counting 0..TIMER_DIV-1; the timer value increments by 1 when the prescaler reaches TIMER_DIV-1, then the prescaler wraps to 0.
REQ-022 The timer SHALL wrap from all-ones to 0 and assert timer_ovf for exactly that one cycle.
REQ-023 A CPU write to the timer in the same cycle as a tick SHALL take priority: the timer loads wr_data, the prescaler resets to 0, and no overflow pulse is produced.
REQ-024 The block SHALL have no ready/stall signalling; every access completes in fixed time, which matches the CPU's fixed read-then-execute sequencing.

Reset
REQ-025 While arst=1 at an edge: rd_data=0, io_out=0, synchronizer=0, timer=0, prescaler=0, timer_ovf=0.
REQ-026 RAM contents SHALL NOT be reset; they hold their values across reset.
REQ-027 A write with we=1 in the same cycle as arst=1 SHALL be discarded, including RAM writes.
REQ-028 Reset asserted mid-count SHALL restart the prescaler from 0 on the first cycle after release.

Configuration
REQ-029 With macro DMEM_TIMER_EN defined, the timer (REQ-021..023) SHALL be present at ALL1-2.
REQ-030 Without DMEM_TIMER_EN, ALL1-2 SHALL be ordinary RAM, timer_ovf tied 0, and no timer logic synthesized.

Structure
REQ-031 The I/O address offsets (IO_OUT, IO_IN, TIMER) SHALL be defined as named constants in the shared defines.v, alongside the opcode and flag definitions.
REQ-032 The timer and prescaler SHALL be a sub-module dmem_timer (ports: clk, arst, load, load_val, value, ovf), instantiated only under DMEM_TIMER_EN.

Verification
REQ-033 The bench SHALL write 0x5A to addr 0x10 (we=1), then read 0x10 -> rd_data=0x5A one clock after addr is presented.
REQ-034 The bench SHALL present the same-cycle read+write of 0x33 to addr 0x20 holding 0x11 -> rd_data=0x11, and the next read returns 0x33.
REQ-035 The bench SHALL write 0xC3 to 0xFF -> io_out=0xC3 after the edge, a read of 0xFF returns 0xC3, and RAM[0xFF] is untouched.
REQ-036 The bench SHALL apply io_in=0x7E, read 0xFE -> 0x7E after 3 clocks; a write of 0x00 to 0xFE leaves the read value at 0x7E.
REQ-037 With DMEM_TIMER_EN and TIMER_DIV=4, the bench SHALL write 0xFE to 0xFD -> value 0xFF after 4 clocks, 0x00 after 8 clocks with timer_ovf high for 1 cycle; a write coinciding with a tick loads with no pulse.
REQ-038 The bench SHALL assert arst mid-operation -> all outputs 0 next cycle, and RAM[0x10] still reads 0x5A after release.
